seg_scan_ctrl: RTL and testbench

Scan controller directly upstream of the `seg` digit decoder in the ALU display path. It accepts 4-bit ALU results and converts each to sign/magnitude form. It keeps a history of the last `DIGITS` results and time-multiplexes them onto one shared `seg` instance via `seg_in`/`o_signbit`, driving a one-hot digit enable. `seg` stays purely combinational; this block owns all sequencing.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_signmag.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the ALU display scan path: history
//                slot layout, FSM state encoding and the 4-bit to
//                sign/magnitude conversion helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // One history slot is {sign, mag[3:0]}
    localparam int SLOT_W   = 5;
    localparam int SIGN_BIT = 4;
    localparam int MAG_MSB  = 3;
    localparam int MAG_LSB  = 0;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_t;

    // Convert a raw ALU result into {sign, magnitude}. In unsigned mode the
    // sign is forced to 0. 4'b1000 in signed mode yields magnitude 8, which
    // still fits the 4-bit field because the negation wraps modulo 16.
    function automatic logic [SLOT_W-1:0] to_signmag(input logic [3:0] value,
                                                     input logic       is_signed);
        logic       sign;
        logic [3:0] mag;
        sign = is_signed & value[3];
        mag  = sign ? (~value + 4'd1) : value;
        to_signmag                   = '0;
        to_signmag[SIGN_BIT]         = sign;
        to_signmag[MAG_MSB:MAG_LSB]  = mag;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_signmag.sv
`default_nettype none
// ============================================================================
//  Module      : seg_signmag
//  Description : Combinational converter from a 4-bit ALU result to the
//                {sign, mag[3:0]} slot format used by the scan history.
//  Ports       : result      - raw 4-bit ALU result
//                signed_mode - 1 = treat result as two's complement
//                slot        - {sign, magnitude} slot value
//  Revision    : 1.0  initial release
// ============================================================================
module seg_signmag
    import seg_pkg::*;
(
    input  logic [3:0]        result,
    input  logic              signed_mode,
    output logic [SLOT_W-1:0] slot
);

    assign slot = to_signmag(result, signed_mode);

endmodule : seg_signmag
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Scan controller feeding a shared combinational `seg` digit
//                decoder. Captures ALU results as sign/magnitude into a
//                DIGITS-deep history (slot 0 newest) and time-multiplexes the
//                slots onto seg_in/o_signbit with a one-hot digit enable.
//  Parameters  : DIGITS   - displayed digits / history depth (1..8)
//                SCAN_DIV - cycles each digit stays enabled (>= 1)
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                i_valid   - one-cycle strobe, new i_result
//                i_result  - 4-bit ALU result
//                i_signed  - 1 = i_result is two's complement
//                seg_in    - registered magnitude to seg
//                o_signbit - registered minus flag to seg
//                o_an      - registered one-hot digit enable
//  Config      : SEG_SCAN_BLANK_EN - when defined, digits whose slot has not
//                yet been filled keep their enable low during their time slot.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [3:0]        i_result,
    input  logic              i_signed,
    output logic [3:0]        seg_in,
    output logic              o_signbit,
    output logic [DIGITS-1:0] o_an
);

    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FILL_W = $clog2(DIGITS + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DIGITS);

    scan_state_t       state;
    logic [SLOT_W-1:0] slots [DIGITS];
    logic [FILL_W-1:0] fill;
    logic [DIV_W-1:0]  div;
    logic [IDX_W-1:0]  idx;

    logic [SLOT_W-1:0] new_slot;
    logic [SLOT_W-1:0] cur_slot;
    logic [DIGITS-1:0] an_next;

    // ------------------------------------------------------------------
    // Input conversion
    // ------------------------------------------------------------------
    seg_signmag u_signmag (
        .result      (i_result),
        .signed_mode (i_signed),
        .slot        (new_slot)
    );

    // ------------------------------------------------------------------
    // Slot select and digit enable for the current idx. Built as an
    // explicit compare loop so non-power-of-two DIGITS never index past
    // the end of the history array.
    // ------------------------------------------------------------------
    always_comb begin
        cur_slot = '0;
        an_next  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_slot   = slots[k];
                an_next[k] = 1'b1;
`ifdef SEG_SCAN_BLANK_EN
                // Unfilled digit: keep its time slot but leave it dark
                if (fill <= FILL_W'(k)) begin
                    an_next[k] = 1'b0;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // History buffer, FSM, divider and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            fill      <= '0;
            div       <= '0;
            idx       <= '0;
            seg_in    <= '0;
            o_signbit <= 1'b0;
            o_an      <= '0;
            for (int k = 0; k < DIGITS; k++) begin
                slots[k] <= '0;
            end
        end else begin
            // New result enters slot 0; everything else ages by one
            if (i_valid) begin
                for (int k = DIGITS - 1; k > 0; k--) begin
                    slots[k] <= slots[k-1];
                end
                slots[0] <= new_slot;
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end

            case (state)
                ST_EMPTY: begin
                    div <= '0;
                    if (i_valid) begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Outputs reflect pre-edge idx/slots, so a result captured
                    // this edge appears on the following one.
                    seg_in    <= cur_slot[MAG_MSB:MAG_LSB];
                    o_signbit <= cur_slot[SIGN_BIT];
                    o_an      <= an_next;
                    if (div == DIV_LAST) begin
                        div <= '0;
                        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=2).
//                A time-based reference model predicts the displayed digit as
//                (cycles since scan start / SCAN_DIV) mod DIGITS and keeps
//                the result history as a plain array.
//  Config      : honours SEG_SCAN_BLANK_EN in the reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 2;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic [3:0]        i_result;
    logic              i_signed;
    logic [3:0]        seg_in;
    logic              o_signbit;
    logic [DIGITS-1:0] o_an;

    int errors = 0;
    int checks = 0;

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_result  (i_result),
        .i_signed  (i_signed),
        .seg_in    (seg_in),
        .o_signbit (o_signbit),
        .o_an      (o_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [4:0] hist [DIGITS];
    int         fill;
    bit         started;
    int         tick;
    logic [3:0] exp_seg;
    logic       exp_sign;
    logic [7:0] exp_an;

    function automatic logic [4:0] ref_conv(input logic [3:0] r, input logic s);
        int v;
        v = (s && r >= 4'd8) ? int'(r) - 16 : int'(r);
        if (v < 0) return {1'b1, 4'(-v)};
        return {1'b0, 4'(v)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DIGITS; k++) hist[k] = '0;
        fill     = 0;
        started  = 0;
        tick     = 0;
        exp_seg  = '0;
        exp_sign = 1'b0;
        exp_an   = '0;
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [3:0] res, input bit s);
        int d;
        if (r) begin
            model_clear();
        end else begin
            if (started) begin
                d        = (tick / SCAN_DIV) % DIGITS;
                exp_seg  = hist[d][3:0];
                exp_sign = hist[d][4];
                exp_an   = 8'(1 << d);
`ifdef SEG_SCAN_BLANK_EN
                if (d >= fill) exp_an = '0;
`endif
                tick++;
            end
            if (v) begin
                for (int k = DIGITS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = ref_conv(res, s);
                if (fill < DIGITS) fill++;
                if (!started) begin
                    started = 1;
                    tick    = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [3:0] res, input bit s);
        @(negedge clk);
        rst      = r;
        i_valid  = v;
        i_result = res;
        i_signed = s;
        @(posedge clk);
        model_edge(r, v, res, s);
        #1;
        check("seg_in",    8'(seg_in),    8'(exp_seg));
        check("o_signbit", 8'(o_signbit), 8'(exp_sign));
        check("o_an",      8'(o_an),      exp_an);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_result = '0; i_signed = 1'b0;
        model_clear();

        // Conversion helper against the arithmetic model, all inputs
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < 2; s++) begin
                check("pkg_conv", 8'(to_signmag(4'(r), 1'(s))), 8'(ref_conv(4'(r), 1'(s))));
            end
        end

        // Reset held 3 cycles, then idle: no digit activity before a result
        repeat (3) step(1, 0, 4'd0, 0);
        idle(6);

        // Unsigned capture
        step(0, 1, 4'd5, 0);
        idle(9);

        // Signed conversion: 1000, 1111, 0111
        step(0, 1, 4'b1000, 1);
        step(0, 1, 4'b1111, 1);
        step(0, 1, 4'b0111, 1);
        idle(10);

        // History overflow
        step(1, 0, 4'd0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 4'(i), 0);
        idle(10);

        // Single value over a full frame (blanking behaviour)
        step(1, 0, 4'd0, 0);
        step(0, 1, 4'd9, 0);
        idle(10);

        // Push on a divider wrap edge, then reset mid-frame
        step(1, 0, 4'd0, 0);
        step(0, 1, 4'd3, 0);
        idle(1);
        step(0, 1, 4'b1100, 1);
        idle(3);
        step(1, 1, 4'd7, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
